// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//   Main control FSM for the multicycle MIPS datapath. Moore outputs are a
//   pure function of the current state. The only exceptions are IRwrite and
//   pcwrite in FETCH, which are gated by the memory handshake so that the
//   instruction register and PC load only on the cycle the fetch completes.
//
// Parameters
//   SUPPORT_EXT   : 1 decodes BNE/ANDI/ORI/JAL, 0 routes them to ILLEGAL
//   MEM_HANDSHAKE : 1 memory states wait for i_mem_ready, 0 never wait
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_op         opcode field of the instruction register
//   i_mem_ready  memory has completed the current access
//   o_IorD       memory address select (0 PC, 1 ALUOut)
//   o_memread    memory read request
//   o_memwrite   memory write request
//   o_IRwrite    instruction register load
//   o_pcwrite    unconditional PC write
//   o_branch     PC write if ALU zero
//   o_branch_ne  PC write if ALU not zero
//   o_regwrite   register file write
//   o_regdst     write register select (00 rt, 01 rd, 10 r31)
//   o_memtoreg   write data select (00 ALUOut, 01 memory, 10 PC)
//   o_alusrcA    ALU A select (0 PC, 1 register A)
//   o_alusrcB    ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   o_zeroext    immediate zero-extension instead of sign-extension
//   o_aluop      000 add, 001 sub, 010 funct, 011 and, 100 or
//   o_pcsrc      PC source (00 ALU, 01 ALUOut, 10 jump target)
//   o_illegal_op one-cycle pulse on an unsupported opcode
//   o_state      current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter logic SUPPORT_EXT   = 1'b1,
  parameter logic MEM_HANDSHAKE = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic       i_mem_ready,
  output logic       o_IorD,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_IRwrite,
  output logic       o_pcwrite,
  output logic       o_branch,
  output logic       o_branch_ne,
  output logic       o_regwrite,
  output logic [1:0] o_regdst,
  output logic [1:0] o_memtoreg,
  output logic       o_alusrcA,
  output logic [1:0] o_alusrcB,
  output logic       o_zeroext,
  output logic [2:0] o_aluop,
  output logic [1:0] o_pcsrc,
  output logic       o_illegal_op,
  output logic [4:0] o_state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_REXEC   = 5'd6,
    S_RWB     = 5'd7,
    S_BEQ     = 5'd8,
    S_ADDIEX  = 5'd9,
    S_IWB     = 5'd10,
    S_JUMP    = 5'd11,
    S_BNE     = 5'd12,
    S_ANDIEX  = 5'd13,
    S_ORIEX   = 5'd14,
    S_JAL     = 5'd15,
    S_ILLEGAL = 5'd16
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_rdy;

  // Without a handshake the memory is assumed single-cycle.
  assign w_rdy   = i_mem_ready | ~MEM_HANDSHAKE;
  assign o_state = r_state;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_IorD       = 1'b0;
    o_memread    = 1'b0;
    o_memwrite   = 1'b0;
    o_IRwrite    = 1'b0;
    o_pcwrite    = 1'b0;
    o_branch     = 1'b0;
    o_branch_ne  = 1'b0;
    o_regwrite   = 1'b0;
    o_regdst     = 2'b00;
    o_memtoreg   = 2'b00;
    o_alusrcA    = 1'b0;
    o_alusrcB    = 2'b00;
    o_zeroext    = 1'b0;
    o_aluop      = ALU_ADD;
    o_pcsrc      = 2'b00;
    o_illegal_op = 1'b0;

    case (r_state)
      S_FETCH: begin
        o_memread = 1'b1;
        o_alusrcB = 2'b01;
        // Load IR and PC+4 only on the completing cycle; the reset term
        // keeps both quiet while the block is held in reset.
        o_IRwrite = w_rdy & i_reset;
        o_pcwrite = w_rdy & i_reset;
        if (w_rdy) w_next = S_DECODE;
      end

      S_DECODE: begin
        // Precompute the branch target in ALUOut while the opcode decodes.
        o_alusrcB = 2'b11;
        case (i_op)
          OP_RTYPE:     w_next = S_REXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQ;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          OP_BNE:       w_next = SUPPORT_EXT ? S_BNE    : S_ILLEGAL;
          OP_ANDI:      w_next = SUPPORT_EXT ? S_ANDIEX : S_ILLEGAL;
          OP_ORI:       w_next = SUPPORT_EXT ? S_ORIEX  : S_ILLEGAL;
          OP_JAL:       w_next = SUPPORT_EXT ? S_JAL    : S_ILLEGAL;
          default:      w_next = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        o_alusrcA = 1'b1;
        o_alusrcB = 2'b10;
        w_next    = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        o_IorD    = 1'b1;
        o_memread = 1'b1;
        if (w_rdy) w_next = S_MEMWB;
      end

      S_MEMWB: begin
        o_memtoreg = 2'b01;
        o_regwrite = 1'b1;
        w_next     = S_FETCH;
      end

      S_MEMWR: begin
        // memwrite stays up for the whole wait so the memory sees a stable
        // request until it acknowledges.
        o_IorD     = 1'b1;
        o_memwrite = 1'b1;
        if (w_rdy) w_next = S_FETCH;
      end

      S_REXEC: begin
        o_alusrcA = 1'b1;
        o_aluop   = ALU_FUNCT;
        w_next    = S_RWB;
      end

      S_RWB: begin
        o_regdst   = 2'b01;
        o_regwrite = 1'b1;
        w_next     = S_FETCH;
      end

      S_BEQ, S_BNE: begin
        o_alusrcA   = 1'b1;
        o_aluop     = ALU_SUB;
        o_pcsrc     = 2'b01;
        o_branch    = (r_state == S_BEQ);
        o_branch_ne = (r_state == S_BNE);
        w_next      = S_FETCH;
      end

      S_ADDIEX, S_ANDIEX, S_ORIEX: begin
        o_alusrcA = 1'b1;
        o_alusrcB = 2'b10;
        // Logical immediates zero-extend; ADDI keeps sign extension.
        o_zeroext = (r_state != S_ADDIEX);
        if (r_state == S_ANDIEX)     o_aluop = ALU_AND;
        else if (r_state == S_ORIEX) o_aluop = ALU_OR;
        else                         o_aluop = ALU_ADD;
        w_next = S_IWB;
      end

      S_IWB: begin
        o_regwrite = 1'b1;
        w_next     = S_FETCH;
      end

      S_JUMP: begin
        o_pcsrc   = 2'b10;
        o_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end

      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        o_pcsrc    = 2'b10;
        o_pcwrite  = 1'b1;
        o_regwrite = 1'b1;
        o_regdst   = 2'b10;
        o_memtoreg = 2'b10;
        w_next     = S_FETCH;
      end

      S_ILLEGAL: begin
        // No architectural writes; PC was already advanced in FETCH.
        o_illegal_op = 1'b1;
        w_next       = S_FETCH;
      end

      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//   Two instances: "a" with extensions and handshake enabled, "b" with both
//   disabled. Directed scenarios plus a randomized run against a per-opcode
//   state-sequence model.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] op_a, op_b;
  logic       mr_a, mr_b;

  logic a_IorD, a_memread, a_memwrite, a_IRwrite, a_pcwrite, a_branch, a_branch_ne, a_regwrite;
  logic [1:0] a_regdst, a_memtoreg, a_alusrcB, a_pcsrc;
  logic a_alusrcA, a_zeroext, a_illegal;
  logic [2:0] a_aluop;
  logic [4:0] a_st;

  logic b_IorD, b_memread, b_memwrite, b_IRwrite, b_pcwrite, b_branch, b_branch_ne, b_regwrite;
  logic [1:0] b_regdst, b_memtoreg, b_alusrcB, b_pcsrc;
  logic b_alusrcA, b_zeroext, b_illegal;
  logic [2:0] b_aluop;
  logic [4:0] b_st;

  mc_control_fsm #(.SUPPORT_EXT(1'b1), .MEM_HANDSHAKE(1'b1)) u_a (
    .i_clk(clk), .i_reset(rst_n), .i_op(op_a), .i_mem_ready(mr_a),
    .o_IorD(a_IorD), .o_memread(a_memread), .o_memwrite(a_memwrite),
    .o_IRwrite(a_IRwrite), .o_pcwrite(a_pcwrite), .o_branch(a_branch),
    .o_branch_ne(a_branch_ne), .o_regwrite(a_regwrite), .o_regdst(a_regdst),
    .o_memtoreg(a_memtoreg), .o_alusrcA(a_alusrcA), .o_alusrcB(a_alusrcB),
    .o_zeroext(a_zeroext), .o_aluop(a_aluop), .o_pcsrc(a_pcsrc),
    .o_illegal_op(a_illegal), .o_state(a_st));

  mc_control_fsm #(.SUPPORT_EXT(1'b0), .MEM_HANDSHAKE(1'b0)) u_b (
    .i_clk(clk), .i_reset(rst_n), .i_op(op_b), .i_mem_ready(mr_b),
    .o_IorD(b_IorD), .o_memread(b_memread), .o_memwrite(b_memwrite),
    .o_IRwrite(b_IRwrite), .o_pcwrite(b_pcwrite), .o_branch(b_branch),
    .o_branch_ne(b_branch_ne), .o_regwrite(b_regwrite), .o_regdst(b_regdst),
    .o_memtoreg(b_memtoreg), .o_alusrcA(b_alusrcA), .o_alusrcB(b_alusrcB),
    .o_zeroext(b_zeroext), .o_aluop(b_aluop), .o_pcsrc(b_pcsrc),
    .o_illegal_op(b_illegal), .o_state(b_st));

  // Packed view: [21]IorD [20]memread [19]memwrite [18]IRwrite [17]pcwrite
  // [16]branch [15]branch_ne [14]regwrite [13:12]regdst [11:10]memtoreg
  // [9]alusrcA [8:7]alusrcB [6]zeroext [5:3]aluop [2:1]pcsrc [0]illegal
  wire [21:0] a_out = {a_IorD, a_memread, a_memwrite, a_IRwrite, a_pcwrite, a_branch,
                       a_branch_ne, a_regwrite, a_regdst, a_memtoreg, a_alusrcA,
                       a_alusrcB, a_zeroext, a_aluop, a_pcsrc, a_illegal};
  wire [21:0] b_out = {b_IorD, b_memread, b_memwrite, b_IRwrite, b_pcwrite, b_branch,
                       b_branch_ne, b_regwrite, b_regdst, b_memtoreg, b_alusrcA,
                       b_alusrcB, b_zeroext, b_aluop, b_pcsrc, b_illegal};

  int n_tests = 0;
  int n_fail  = 0;

  // Control word each state must present, from the state table.
  function automatic logic [21:0] exp_out(input logic [4:0] s, input logic rdy);
    logic iord, mrd, mwr, irw, pcw, br, bne, rw, asa, zx, ill;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] aop;
    {iord, mrd, mwr, irw, pcw, br, bne, rw, asa, zx, ill} = '0;
    rd = 2'b00; m2r = 2'b00; asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (s)
      5'd0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      5'd1:  asb = 2'b11;
      5'd2:  begin asa = 1; asb = 2'b10; end
      5'd3:  begin iord = 1; mrd = 1; end
      5'd4:  begin m2r = 2'b01; rw = 1; end
      5'd5:  begin iord = 1; mwr = 1; end
      5'd6:  begin asa = 1; aop = 3'b010; end
      5'd7:  begin rd = 2'b01; rw = 1; end
      5'd8:  begin asa = 1; aop = 3'b001; pcs = 2'b01; br = 1; end
      5'd9:  begin asa = 1; asb = 2'b10; end
      5'd10: rw = 1;
      5'd11: begin pcs = 2'b10; pcw = 1; end
      5'd12: begin asa = 1; aop = 3'b001; pcs = 2'b01; bne = 1; end
      5'd13: begin asa = 1; asb = 2'b10; aop = 3'b011; zx = 1; end
      5'd14: begin asa = 1; asb = 2'b10; aop = 3'b100; zx = 1; end
      5'd15: begin pcs = 2'b10; pcw = 1; rw = 1; rd = 2'b10; m2r = 2'b10; end
      5'd16: ill = 1;
      default: ;
    endcase
    return {iord, mrd, mwr, irw, pcw, br, bne, rw, rd, m2r, asa, asb, zx, aop, pcs, ill};
  endfunction

  // Holds reset for two cycles, releases on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_a = 6'd0; op_b = 6'd0; mr_a = 1'b1; mr_b = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (a_st !== 5'd0) begin n_fail++; $display("FAIL reset_state_a: got %0d want 0", a_st); end
    n_tests++;
    if (a_out !== exp_out(5'd0, 1'b0)) begin n_fail++; $display("FAIL reset_out_a: got %h want %h", a_out, exp_out(5'd0, 1'b0)); end
    n_tests++;
    if (b_st !== 5'd0 || b_IRwrite !== 1'b0 || b_pcwrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: state %0d IRwrite %b pcwrite %b want 0 0 0", b_st, b_IRwrite, b_pcwrite);
    end
    @(negedge clk);
    mr_a = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [4:0] es [5];
    es = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd0};
    @(negedge clk);
    op_a = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      mr_a = (i != 4);
      #1;
      n_tests++;
      if (a_st !== es[i]) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, a_st, es[i]); end
      n_tests++;
      if (a_out !== exp_out(es[i], mr_a)) begin n_fail++; $display("FAIL rtype_out[%0d]: got %h want %h", i, a_out, exp_out(es[i], mr_a)); end
      if (i == 2) begin
        n_tests++;
        if (a_aluop !== 3'b010) begin n_fail++; $display("FAIL rtype_aluop: got %b want 010", a_aluop); end
      end
      if (i == 3) begin
        n_tests++;
        if (a_regwrite !== 1'b1 || a_regdst !== 2'b01) begin
          n_fail++; $display("FAIL rtype_wb: regwrite %b regdst %b want 1 01", a_regwrite, a_regdst);
        end
      end
      if (i != 4) @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    logic [4:0] es [9];
    logic       mrs [9];
    int         wb_cnt;
    es  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd4, 5'd0};
    mrs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    wb_cnt = 0;
    @(negedge clk);
    op_a = 6'b100011;
    for (int i = 0; i < 9; i++) begin
      mr_a = mrs[i];
      #1;
      n_tests++;
      if (a_st !== es[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, a_st, es[i]); end
      n_tests++;
      if (a_out !== exp_out(es[i], mr_a)) begin n_fail++; $display("FAIL lw_out[%0d]: got %h want %h", i, a_out, exp_out(es[i], mr_a)); end
      if (a_regwrite === 1'b1 && a_memtoreg === 2'b01) wb_cnt++;
      if (i != 8) @(negedge clk);
    end
    n_tests++;
    if (wb_cnt != 1) begin n_fail++; $display("FAIL lw_writeback_count: got %0d want 1", wb_cnt); end
  endtask

  task automatic test_fetch_stall();
    logic [4:0] es [6];
    logic       mrs [6];
    es  = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd11, 5'd0};
    mrs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    op_a = 6'b000010;
    for (int i = 0; i < 6; i++) begin
      mr_a = mrs[i];
      #1;
      n_tests++;
      if (a_st !== es[i]) begin n_fail++; $display("FAIL stall_state[%0d]: got %0d want %0d", i, a_st, es[i]); end
      n_tests++;
      if (a_out !== exp_out(es[i], mr_a)) begin n_fail++; $display("FAIL stall_out[%0d]: got %h want %h", i, a_out, exp_out(es[i], mr_a)); end
      if (i < 3) begin
        n_tests++;
        if (a_IRwrite !== (i == 2) || a_pcwrite !== (i == 2)) begin
          n_fail++; $display("FAIL stall_irpc[%0d]: IRwrite %b pcwrite %b want %b", i, a_IRwrite, a_pcwrite, (i == 2));
        end
      end
      if (i != 5) @(negedge clk);
    end
  endtask

  task automatic test_ext();
    logic [4:0] es  [8];
    logic [5:0] ops [8];
    es  = '{5'd0, 5'd1, 5'd14, 5'd10, 5'd0, 5'd1, 5'd15, 5'd0};
    ops = '{6'b001101, 6'b001101, 6'b111111, 6'b100011,
            6'b000011, 6'b000011, 6'b000000, 6'b101011};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      op_a = ops[i];
      mr_a = (i != 7);
      #1;
      n_tests++;
      if (a_st !== es[i]) begin n_fail++; $display("FAIL ext_state[%0d]: got %0d want %0d", i, a_st, es[i]); end
      n_tests++;
      if (a_out !== exp_out(es[i], mr_a)) begin n_fail++; $display("FAIL ext_out[%0d]: got %h want %h", i, a_out, exp_out(es[i], mr_a)); end
      if (i == 2) begin
        n_tests++;
        if (a_aluop !== 3'b100 || a_zeroext !== 1'b1) begin
          n_fail++; $display("FAIL ori_exec: aluop %b zeroext %b want 100 1", a_aluop, a_zeroext);
        end
      end
      if (i == 6) begin
        n_tests++;
        if ({a_pcwrite, a_regwrite, a_regdst, a_memtoreg} !== 6'b111010) begin
          n_fail++; $display("FAIL jal: pcwrite,regwrite,regdst,memtoreg %b want 111010",
                             {a_pcwrite, a_regwrite, a_regdst, a_memtoreg});
        end
      end
      if (i != 7) @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] es [5];
    es = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd5};
    @(negedge clk);
    op_a = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mr_a = (i < 3);
      #1;
      n_tests++;
      if (a_st !== es[i] || a_out !== exp_out(es[i], mr_a)) begin
        n_fail++; $display("FAIL sw_wait[%0d]: state %0d out %h want %0d %h", i, a_st, a_out, es[i], exp_out(es[i], mr_a));
      end
      if (i != 4) @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (a_st !== 5'd0 || a_memwrite !== 1'b0 || a_IRwrite !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: state %0d memwrite %b IRwrite %b want 0 0 0", a_st, a_memwrite, a_IRwrite);
    end
    @(negedge clk);
    mr_a = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_illegal();
    logic [4:0] ea [7];
    logic [4:0] eb [7];
    logic [5:0] ops [7];
    ea  = '{5'd0, 5'd1, 5'd12, 5'd0, 5'd1, 5'd16, 5'd0};
    eb  = '{5'd0, 5'd1, 5'd16, 5'd0, 5'd1, 5'd16, 5'd0};
    ops = '{6'b000101, 6'b000101, 6'b000000, 6'b111111, 6'b111111, 6'b000100, 6'b000000};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      op_a = ops[i]; op_b = ops[i];
      mr_a = (i != 6);
      mr_b = 1'b0;
      #1;
      n_tests++;
      if (a_st !== ea[i] || a_out !== exp_out(ea[i], mr_a)) begin
        n_fail++; $display("FAIL illegal_a[%0d]: state %0d out %h want %0d %h", i, a_st, a_out, ea[i], exp_out(ea[i], mr_a));
      end
      n_tests++;
      if (b_st !== eb[i] || b_out !== exp_out(eb[i], 1'b1)) begin
        n_fail++; $display("FAIL illegal_b[%0d]: state %0d out %h want %0d %h", i, b_st, b_out, eb[i], exp_out(eb[i], 1'b1));
      end
      if (eb[i] == 5'd16) begin
        n_tests++;
        if (b_illegal !== 1'b1 || b_branch_ne !== 1'b0 || b_regwrite !== 1'b0 || b_memwrite !== 1'b0) begin
          n_fail++; $display("FAIL illegal_pulse: illegal %b bne %b regwrite %b memwrite %b want 1 0 0 0",
                             b_illegal, b_branch_ne, b_regwrite, b_memwrite);
        end
      end
      if (i != 6) @(negedge clk);
    end
  endtask

  // Reference model: each instruction is the ordered list of states it walks.
  logic [4:0] seq [2][8];
  int         len [2];
  int         pos [2];
  logic [5:0] cur [2];

  task automatic build(input int k);
    logic [5:0] o;
    logic       ext;
    int         pick;
    ext  = (k == 0);
    pick = $urandom_range(0, 11);
    case (pick)
      0: o = 6'b000000;  1: o = 6'b100011;  2: o = 6'b101011;  3: o = 6'b000100;
      4: o = 6'b001000;  5: o = 6'b000010;  6: o = 6'b000101;  7: o = 6'b001100;
      8: o = 6'b001101;  9: o = 6'b000011; 10: o = 6'b111111;
      default: o = 6'($urandom);
    endcase
    cur[k] = o; pos[k] = 0;
    seq[k][0] = 5'd0; seq[k][1] = 5'd1; len[k] = 3;
    if (o == 6'b000000)               begin seq[k][2] = 5'd6;  seq[k][3] = 5'd7;  len[k] = 4; end
    else if (o == 6'b100011)          begin seq[k][2] = 5'd2;  seq[k][3] = 5'd3;  seq[k][4] = 5'd4; len[k] = 5; end
    else if (o == 6'b101011)          begin seq[k][2] = 5'd2;  seq[k][3] = 5'd5;  len[k] = 4; end
    else if (o == 6'b000100)                seq[k][2] = 5'd8;
    else if (o == 6'b001000)          begin seq[k][2] = 5'd9;  seq[k][3] = 5'd10; len[k] = 4; end
    else if (o == 6'b000010)                seq[k][2] = 5'd11;
    else if (ext && o == 6'b000101)         seq[k][2] = 5'd12;
    else if (ext && o == 6'b001100)   begin seq[k][2] = 5'd13; seq[k][3] = 5'd10; len[k] = 4; end
    else if (ext && o == 6'b001101)   begin seq[k][2] = 5'd14; seq[k][3] = 5'd10; len[k] = 4; end
    else if (ext && o == 6'b000011)         seq[k][2] = 5'd15;
    else                                    seq[k][2] = 5'd16;
  endtask

  task automatic test_random();
    logic [4:0]  s   [2];
    logic [5:0]  opv [2];
    logic        mrv [2];
    logic        rdy [2];
    logic [4:0]  gst;
    logic [21:0] gout;
    do_reset();
    build(0);
    build(1);
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        s[k]   = seq[k][pos[k]];
        // The opcode only matters in DECODE/MEMADR; elsewhere it is noise.
        opv[k] = (s[k] == 5'd1 || s[k] == 5'd2) ? cur[k] : 6'($urandom);
        mrv[k] = ($urandom_range(0, 2) != 0);
        rdy[k] = mrv[k] | (k == 1);
      end
      op_a = opv[0]; mr_a = mrv[0];
      op_b = opv[1]; mr_b = mrv[1];
      #1;
      for (int k = 0; k < 2; k++) begin
        gst  = (k == 0) ? a_st  : b_st;
        gout = (k == 0) ? a_out : b_out;
        n_tests++;
        if (gst !== s[k]) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL rand_state[%0d] dut%0d op %b: got %0d want %0d", c, k, cur[k], gst, s[k]);
        end
        n_tests++;
        if (gout !== exp_out(s[k], rdy[k])) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL rand_out[%0d] dut%0d state %0d: got %h want %h", c, k, s[k], gout, exp_out(s[k], rdy[k]));
        end
        if ((s[k] == 5'd0 || s[k] == 5'd3 || s[k] == 5'd5) && !rdy[k]) begin
          // memory wait: stay on this step
        end else begin
          pos[k]++;
          if (pos[k] == len[k]) build(k);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_fetch_stall();
    test_ext();
    test_async_reset();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
